ex_forward_unit: RTL and testbench
==================================

Name: ex_forward_unit

Overview:
- EX-stage consumer of the ID/EX pipeline register outputs.
- Tracks the destinations of the two older in-flight instructions in internal EX/MEM and MEM/WB shadow registers.
- Produces forwarded ALU operands and raises a load-use stall when the EX instruction needs a value that is still in memory.
- Sits between the ID/EX register and the ALU. Its stall output holds the PC, IF/ID and ID/EX registers.

Parameters:
- DW, 32, datapath width
- AW, 5, register address width
- CW, 8, control bus width

Ports:
- clk  in  1  pipeline clock; state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- ctrl_in  in  CW  control of the EX instruction. Bit 0 RegWrite, bit 1 MemToReg, bit 2 MemRead, bit 3 MemWrite, bit 4 RegDst, bit 5 ALUSrc, bits 7:6 ALUOp.
- rs_addr_in  in  AW  source register rs of the EX instruction
- rt_addr_in  in  AW  source register rt of the EX instruction
- rd_addr_in  in  AW  rd field of the EX instruction
- rs_data_in  in  DW  register-file value of rs
- rt_data_in  in  DW  register-file value of rt
- alu_result_in  in  DW  ALU output of the current EX instruction
- mem_rdata_in  in  DW  data-memory read data for the instruction in the MEM stage
- flush  in  1  squash the EX instruction (branch taken)
- op_a_out  out  DW  forwarded operand A
- op_b_out  out  DW  forwarded operand B, before the ALUSrc mux
- fwd_a_sel  out  2  operand A source: 0 register file, 1 EX/MEM, 2 MEM/WB
- fwd_b_sel  out  2  operand B source, same encoding as fwd_a_sel
- stall  out  1  load-use stall request
- wb_we  out  1  MEM/WB RegWrite
- wb_addr  out  AW  MEM/WB destination register
- wb_data  out  DW  MEM/WB writeback value

Behaviour:
- Destination of the EX instruction: rd_addr_in when ctrl_in[4]=1, else rt_addr_in.
- EX/MEM shadow registers: em_we, em_load, em_dst, em_res.
- MEM/WB shadow registers: mw_we, mw_dst, mw_data.
- Reset (async, rst=1): all shadow registers go to 0 immediately. Consequently fwd_*_sel=0, op_a_out=rs_data_in, op_b_out=rt_data_in, stall=0, wb_we=0, wb_addr=0, wb_data=0. Reset released mid-stream: the first edge after release captures normally.
- Each rising edge (rst=0):
  - MEM/WB <= EX/MEM. mw_data <= mem_rdata_in if em_load=1, else em_res.
  - EX/MEM <= EX instruction: em_we=ctrl_in[0], em_load=ctrl_in[2], em_dst=destination, em_res=alu_result_in.
  - Bubble: if stall=1 or flush=1, EX/MEM captures a bubble instead (em_we=0, em_load=0, em_dst=0, em_res=0). MEM/WB still advances.
- Forwarding is combinational from the shadow registers. Rule for operand A (rs); operand B (rt) is identical:
  - If em_we=1, em_load=0, em_dst!=0 and em_dst==rs: sel=1, value em_res.
  - Otherwise, if mw_we=1, mw_dst!=0 and mw_dst==rs: sel=2, value mw_data.
  - Otherwise sel=0, value rs_data_in.
  - EX/MEM has priority over MEM/WB when both match.
  - Register 0 is never forwarded.
- stall = em_load & em_we & (em_dst!=0) & ((em_dst==rs_addr_in) | (em_dst==rt_addr_in & ~ctrl_in[5])).
  - A stall lasts exactly 1 cycle: the next edge bubbles EX/MEM, so em_load is 0 on the following cycle. The load then sits in MEM/WB and is forwarded with sel=2.
  - While stall=1, the forwarded outputs are don't-care. Upstream holds ID/EX, so the same instruction is re-presented.
  - stall and flush together: flush wins for upstream control, and EX/MEM bubbles once.
- wb_we, wb_addr and wb_data come directly from the MEM/WB shadow registers. They drive the register-file write port (write-first is the register file's responsibility).
- Latency:
  - Forwarded operands: 0 cycles (combinational).
  - Shadow tracking: 1 cycle per stage.
  - Writeback: 2 edges after the instruction leaves EX.

Test Plan:
1. Reset mid-stream: assert rst between edges with em_we=1 -> immediately wb_we=0, fwd_a_sel=0, stall=0; op_a_out equals rs_data_in=0x1234.
2. Back-to-back ALU dependency: add r3 with alu_result=0x55, next EX instruction reads rs=r3, rs_data_in=0 -> fwd_a_sel=1, op_a_out=0x55.
3. Two-apart dependency: instruction writes r4=0x77, an unrelated instruction follows, then rt=r4 with ALUSrc=0 -> fwd_b_sel=2, op_b_out=0x77. Double match with EX/MEM r4=0x88 -> sel=1, value 0x88.
4. Load-use: lw r5 (MemRead=1, RegWrite=1), next EX instruction reads rs=r5 -> stall=1 for exactly 1 cycle. After the edge: stall=0, fwd_a_sel=2, op_a_out=mem_rdata_in captured value 0xCAFE.
5. $zero and ALUSrc: writer with dst=0, reader rs=0 -> sel=0. Load to r6 followed by a reader with rt=r6 and ALUSrc=1 -> stall=0.
6. Flush: flush=1 while the EX instruction writes r7 -> the next cycle's reader of r7 gets sel=0. Two cycles later, wb_we=0 for that slot.

Source files
------------

// File: rtl/ex_forward_unit.sv
// rtl/ex_forward_unit.sv - EX-stage operand forwarding and load-use stall detection
//
// Shadows the EX/MEM and MEM/WB destination state of the two older in-flight
// instructions so that the EX instruction can pick up results that have not
// reached the register file yet.
//
// Ports:
//   clk, rst        pipeline clock, asynchronous active-high reset
//   ctrl_in         EX control: [0] RegWrite [1] MemToReg [2] MemRead
//                   [3] MemWrite [4] RegDst [5] ALUSrc [7:6] ALUOp
//   rs/rt/rd_addr_in, rs/rt_data_in   EX register fields and file values
//   alu_result_in   ALU output of the EX instruction
//   mem_rdata_in    load data for the instruction in MEM
//   flush           squash the EX instruction
//   op_a_out/op_b_out, fwd_a_sel/fwd_b_sel   forwarded operands and sources
//   stall           load-use stall request
//   wb_we/wb_addr/wb_data                    register-file write port
module ex_forward_unit #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] ctrl_in,
  input  logic [AW-1:0] rs_addr_in,
  input  logic [AW-1:0] rt_addr_in,
  input  logic [AW-1:0] rd_addr_in,
  input  logic [DW-1:0] rs_data_in,
  input  logic [DW-1:0] rt_data_in,
  input  logic [DW-1:0] alu_result_in,
  input  logic [DW-1:0] mem_rdata_in,
  input  logic          flush,
  output logic [DW-1:0] op_a_out,
  output logic [DW-1:0] op_b_out,
  output logic [1:0]    fwd_a_sel,
  output logic [1:0]    fwd_b_sel,
  output logic          stall,
  output logic          wb_we,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data
);

  logic          em_we;
  logic          em_load;
  logic [AW-1:0] em_dst;
  logic [DW-1:0] em_res;
  logic          mw_we;
  logic [AW-1:0] mw_dst;
  logic [DW-1:0] mw_data;

  logic          reg_write;
  logic          mem_read;
  logic          reg_dst;
  logic          alu_src;
  logic [AW-1:0] ex_dst;

  // MemToReg, MemWrite and ALUOp belong to later stages and are not used here.
  logic unused_ctrl;
  assign unused_ctrl = ^{ctrl_in[CW-1:6], ctrl_in[3], ctrl_in[1]};

  assign reg_write = ctrl_in[0];
  assign mem_read  = ctrl_in[2];
  assign reg_dst   = ctrl_in[4];
  assign alu_src   = ctrl_in[5];
  assign ex_dst    = reg_dst ? rd_addr_in : rt_addr_in;

  // rt only counts as a use when it feeds the ALU, i.e. ALUSrc selects it.
  assign stall = em_load && em_we && (em_dst != '0) &&
                 ((em_dst == rs_addr_in) || ((em_dst == rt_addr_in) && !alu_src));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      em_we   <= 1'b0;
      em_load <= 1'b0;
      em_dst  <= '0;
      em_res  <= '0;
      mw_we   <= 1'b0;
      mw_dst  <= '0;
      mw_data <= '0;
    end else begin
      mw_we   <= em_we;
      mw_dst  <= em_dst;
      mw_data <= em_load ? mem_rdata_in : em_res;
      if (stall || flush) begin
        em_we   <= 1'b0;
        em_load <= 1'b0;
        em_dst  <= '0;
        em_res  <= '0;
      end else begin
        em_we   <= reg_write;
        em_load <= mem_read;
        em_dst  <= ex_dst;
        em_res  <= alu_result_in;
      end
    end
  end

  // A load in EX/MEM has no data yet, so it never forwards from there; the
  // search falls through to MEM/WB (the stall covers the actual hazard).
  always_comb begin
    fwd_a_sel = 2'd0;
    op_a_out  = rs_data_in;
    if (em_we && !em_load && (em_dst != '0) && (em_dst == rs_addr_in)) begin
      fwd_a_sel = 2'd1;
      op_a_out  = em_res;
    end else if (mw_we && (mw_dst != '0) && (mw_dst == rs_addr_in)) begin
      fwd_a_sel = 2'd2;
      op_a_out  = mw_data;
    end
  end

  always_comb begin
    fwd_b_sel = 2'd0;
    op_b_out  = rt_data_in;
    if (em_we && !em_load && (em_dst != '0) && (em_dst == rt_addr_in)) begin
      fwd_b_sel = 2'd1;
      op_b_out  = em_res;
    end else if (mw_we && (mw_dst != '0) && (mw_dst == rt_addr_in)) begin
      fwd_b_sel = 2'd2;
      op_b_out  = mw_data;
    end
  end

  assign wb_we   = mw_we;
  assign wb_addr = mw_dst;
  assign wb_data = mw_data;

endmodule

// File: tb/tb_ex_forward_unit.sv
// tb/tb_ex_forward_unit.sv - scoreboard bench for ex_forward_unit
module tb_ex_forward_unit;

  localparam logic [7:0] C_RW  = 8'h01;
  localparam logic [7:0] C_MTR = 8'h02;
  localparam logic [7:0] C_MR  = 8'h04;
  localparam logic [7:0] C_RD  = 8'h10;
  localparam logic [7:0] C_AS  = 8'h20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ctrl_in = '0;
  logic [4:0]  rs_addr_in = '0, rt_addr_in = '0, rd_addr_in = '0;
  logic [31:0] rs_data_in = '0, rt_data_in = '0, alu_result_in = '0, mem_rdata_in = '0;
  logic        flush = 1'b0;
  logic [31:0] op_a_out, op_b_out, wb_data;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall, wb_we;
  logic [4:0]  wb_addr;

  ex_forward_unit dut (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in),
    .rs_addr_in(rs_addr_in), .rt_addr_in(rt_addr_in), .rd_addr_in(rd_addr_in),
    .rs_data_in(rs_data_in), .rt_data_in(rt_data_in),
    .alu_result_in(alu_result_in), .mem_rdata_in(mem_rdata_in), .flush(flush),
    .op_a_out(op_a_out), .op_b_out(op_b_out),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // In-flight history: hist[0] is the most recently retired-from-EX
  // instruction, hist[1] the one before it (value already resolved).
  typedef struct {
    logic        we;
    logic        load;
    logic [4:0]  dst;
    logic [31:0] val;
  } slot_t;

  typedef struct {
    logic        stall;
    logic [1:0]  sa, sb;
    logic [31:0] oa, ob;
    logic        wwe;
    logic [4:0]  wa;
    logic [31:0] wd;
  } exp_t;

  slot_t hist [2];
  exp_t  sbq [$];
  int    checks = 0;
  int    errors = 0;
  logic  model_stall;

  function automatic slot_t empty_slot();
    slot_t s;
    s.we = 1'b0; s.load = 1'b0; s.dst = '0; s.val = '0;
    return s;
  endfunction

  task automatic model_clear();
    hist[0] = empty_slot();
    hist[1] = empty_slot();
  endtask

  // Newest producer wins; a load that has not reached memory yet cannot supply.
  task automatic lookup(input logic [4:0] r, input logic [31:0] rf,
                        output logic [1:0] sel, output logic [31:0] v);
    sel = 2'd0;
    v   = rf;
    for (int age = 1; age >= 0; age--) begin
      if (hist[age].we && hist[age].dst != 0 && hist[age].dst == r &&
          !(age == 0 && hist[age].load)) begin
        sel = 2'(age + 1);
        v   = hist[age].val;
      end
    end
  endtask

  task automatic push_expect();
    exp_t e;
    logic uses_rt;
    uses_rt = (ctrl_in & C_AS) == 0;
    e.stall = hist[0].load && hist[0].we && hist[0].dst != 0 &&
              (hist[0].dst == rs_addr_in || (uses_rt && hist[0].dst == rt_addr_in));
    lookup(rs_addr_in, rs_data_in, e.sa, e.oa);
    lookup(rt_addr_in, rt_data_in, e.sb, e.ob);
    e.wwe = hist[1].we;
    e.wa  = hist[1].dst;
    e.wd  = hist[1].val;
    model_stall = e.stall;
    sbq.push_back(e);
  endtask

  task automatic model_edge();
    slot_t nw, ne;
    if (rst) begin
      model_clear();
    end else begin
      nw = hist[0];
      if (hist[0].load) nw.val = mem_rdata_in;
      ne = empty_slot();
      if (!model_stall && !flush) begin
        ne.we   = ctrl_in[0];
        ne.load = ctrl_in[2];
        ne.dst  = ctrl_in[4] ? rd_addr_in : rt_addr_in;
        ne.val  = alu_result_in;
      end
      hist[1] = nw;
      hist[0] = ne;
    end
  endtask

  // Present one EX-stage cycle, record its expected outputs, then clock it.
  task automatic issue(input logic r, input logic [7:0] c,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [31:0] alu, input logic [31:0] mrd, input logic fl);
    rst = r;
    ctrl_in = c; rs_addr_in = rs; rt_addr_in = rt; rd_addr_in = rd;
    rs_data_in = rsd; rt_data_in = rtd; alu_result_in = alu;
    mem_rdata_in = mrd; flush = fl;
    if (r) model_clear();
    push_expect();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("stall", 32'(stall), 32'(e.stall));
        check("wb_we", 32'(wb_we), 32'(e.wwe));
        check("wb_addr", 32'(wb_addr), 32'(e.wa));
        check("wb_data", wb_data, e.wd);
        if (!e.stall) begin
          check("fwd_a_sel", 32'(fwd_a_sel), 32'(e.sa));
          check("fwd_b_sel", 32'(fwd_b_sel), 32'(e.sb));
          check("op_a_out", op_a_out, e.oa);
          check("op_b_out", op_b_out, e.ob);
        end
      end
    end
  end

  initial begin : driver
    logic [7:0]  c;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, alu;
    logic        fl;
    int          budget;
    model_clear();
    model_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Reset mid-stream: a writer enters EX/MEM, then reset lands between edges.
    issue(0, C_RW | C_RD, 1, 2, 9, 0, 0, 32'h99, 0, 0);
    issue(0, C_RW | C_RD, 9, 2, 10, 0, 0, 32'h98, 0, 0);
    issue(1, 0, 9, 0, 0, 32'h1234, 0, 0, 0, 0);
    // Back-to-back ALU dependency on r3.
    issue(0, C_RW | C_RD, 1, 2, 3, 0, 0, 32'h55, 0, 0);
    issue(0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    // Two-apart dependency on r4, then double match.
    issue(0, C_RW | C_RD, 1, 2, 4, 0, 0, 32'h77, 0, 0);
    issue(0, C_RW | C_RD, 1, 2, 8, 0, 0, 32'h11, 0, 0);
    issue(0, 0, 0, 4, 0, 0, 0, 0, 0, 0);
    issue(0, C_RW | C_RD, 1, 2, 4, 0, 0, 32'h77, 0, 0);
    issue(0, C_RW | C_RD, 1, 2, 4, 0, 0, 32'h88, 0, 0);
    issue(0, 0, 0, 4, 0, 0, 0, 0, 0, 0);
    // Load-use on r5: stall once, then the loaded value arrives from MEM/WB.
    issue(0, C_RW | C_MR | C_MTR, 1, 5, 0, 0, 0, 32'h40, 0, 0);
    issue(0, 0, 5, 0, 0, 0, 0, 0, 32'hCAFE, 0);
    issue(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    // $zero is never forwarded; ALUSrc=1 hides an rt match from the stall.
    issue(0, C_RW | C_RD, 1, 2, 0, 0, 0, 32'hDEAD, 0, 0);
    issue(0, 0, 0, 0, 0, 32'h5, 32'h6, 0, 0, 0);
    issue(0, C_RW | C_MR, 1, 6, 0, 0, 0, 0, 0, 0);
    issue(0, C_AS, 1, 6, 0, 0, 0, 0, 32'hBEEF, 0);
    // Flush of a writer to r7.
    issue(0, C_RW | C_RD, 1, 2, 7, 0, 0, 32'h70, 0, 1);
    issue(0, 0, 7, 7, 0, 32'h3, 32'h4, 0, 0, 0);
    issue(0, 0, 7, 7, 0, 32'h3, 32'h4, 0, 0, 0);
    issue(0, 0, 7, 7, 0, 32'h3, 32'h4, 0, 0, 0);
    // Random traffic on a narrow register range to provoke hazards.
    c = 0; rs = 0; rt = 0; rd = 0; rsd = 0; rtd = 0; alu = 0;
    for (int i = 0; i < 600; i++) begin
      if (!(model_stall && !flush)) begin
        c = 8'($urandom);
        if ($urandom_range(0, 9) < 7) c = c | C_RW;
        if ($urandom_range(0, 9) < 6) c = c & ~C_MR;
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        rsd = $urandom; rtd = $urandom; alu = $urandom;
      end
      fl = ($urandom_range(0, 9) == 0);
      issue(($urandom_range(0, 99) == 0), c, rs, rt, rd, rsd, rtd, alu, $urandom, fl);
    end
    budget = 0;
    while (sbq.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
